// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the framed program loader.
// Holds the FSM state encoding, the error codes and the frame markers.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_TGT, ST_LEN0, ST_LEN1, ST_DATA, ST_CHK, ST_ERR
  } state_e;

  typedef enum logic [2:0] {
    E_NONE    = 3'd0,
    E_BAD_TGT = 3'd1,
    E_BAD_LEN = 3'd2,
    E_BAD_CHK = 3'd3,
    E_TIMEOUT = 3'd4,
    E_ABORT   = 3'd5
  } err_e;

  localparam logic [7:0] EOS_BYTE = 8'hFF;
  localparam int         MAX_TGT  = 8;

  function automatic logic in_session(state_e s);
    return !(s == ST_IDLE || s == ST_ERR);
  endfunction

endpackage

// File: rtl/prog_word_assembler.sv
// Packs little-endian bytes into a DataW word; word_valid_o is combinational
// on the last byte so the parent can register the write one cycle later.
module prog_word_assembler #(
  parameter int DataW = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [7:0]       byte_i,
  output logic             word_valid_o,
  output logic [DataW-1:0] word_o
);

  localparam int             Bytes    = DataW / 8;
  localparam int             LaneW    = (Bytes > 1) ? $clog2(Bytes) : 1;
  localparam logic [LaneW-1:0] LastLane = LaneW'(Bytes - 1);

  logic [LaneW-1:0] lane;
  logic [DataW-1:0] sr;

  // New bytes enter at the top so the first byte ends up in bits [7:0].
  if (DataW == 8) begin : g_byte
    assign word_o = byte_i;
  end else begin : g_wide
    assign word_o = {byte_i, sr[DataW-1:8]};
  end

  assign word_valid_o = en_i && (lane == LastLane);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      lane <= '0;
      sr   <= '0;
    end else if (en_i) begin
      lane <= word_valid_o ? '0 : lane + 1'b1;
      sr   <= word_o;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed program loader: decodes TGT/LEN/words/CHK frames from the UART byte
// stream, writes one of NumTgt memories and holds system reset during a session.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DataW      = 32,
  parameter int AddrW      = 12,
  parameter int NumTgt     = 2,
  parameter int TimeoutCyc = 100000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              prog_i,
  input  logic              rx_dv_i,
  input  logic [7:0]        rx_byte_i,
  output logic [NumTgt-1:0] we_o,
  output logic [AddrW-1:0]  addr_o,
  output logic [DataW-1:0]  wdata_o,
  output logic              prog_rst_no,
  output logic              busy_o,
  output logic              done_o,
  output logic [2:0]        err_o
);

  localparam int             TgtW    = $clog2(MAX_TGT);
  localparam int             TcW     = $clog2(TimeoutCyc + 1);
  localparam logic [7:0]     NumTgtB = 8'(NumTgt);
  localparam logic [31:0]    MaxLen  = 32'(1) << AddrW;
  localparam logic [TcW-1:0] TcLast  = TcW'(TimeoutCyc - 1);

  state_e st, st_d;
  err_e   fault;

  logic [TgtW-1:0]  tgt;
  logic [7:0]       len_lo, sum, sum_nx;
  logic [15:0]      n_rem, len_nx;
  logic [AddrW-1:0] waddr;
  logic [TcW-1:0]   tcnt;
  logic             word_valid;
  logic [DataW-1:0] word;

  logic [NumTgt-1:0] we_d;
  logic [AddrW-1:0]  addr_d;
  logic [DataW-1:0]  wdata_d;
  logic              done_d, busy_d, prst_d;
  logic [2:0]        err_d;

  assign sum_nx = sum + rx_byte_i;
  assign len_nx = {rx_byte_i, len_lo};

  prog_word_assembler #(.DataW(DataW)) u_asm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (st != ST_DATA),
    .en_i         (st == ST_DATA && rx_dv_i),
    .byte_i       (rx_byte_i),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st          <= ST_IDLE;
      we_o        <= '0;
      addr_o      <= '0;
      wdata_o     <= '0;
      prog_rst_no <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= '0;
    end else begin
      st          <= st_d;
      we_o        <= we_d;
      addr_o      <= addr_d;
      wdata_o     <= wdata_d;
      prog_rst_no <= prst_d;
      busy_o      <= busy_d;
      done_o      <= done_d;
      err_o       <= err_d;
    end
  end

  always_comb begin
    st_d  = st;
    fault = E_NONE;
    unique case (st)
      ST_IDLE: if (prog_i) st_d = ST_TGT;
      ST_TGT: if (rx_dv_i) begin
        if (rx_byte_i == EOS_BYTE)     st_d  = ST_IDLE;
        else if (rx_byte_i < NumTgtB)  st_d  = ST_LEN0;
        else                           fault = E_BAD_TGT;
      end
      ST_LEN0: if (rx_dv_i) st_d = ST_LEN1;
      ST_LEN1: if (rx_dv_i) begin
        if (32'(len_nx) > MaxLen) fault = E_BAD_LEN;
        else if (len_nx == '0)    st_d  = ST_CHK;
        else                      st_d  = ST_DATA;
      end
      ST_DATA: if (word_valid && n_rem == 16'd1) st_d = ST_CHK;
      ST_CHK: if (rx_dv_i) begin
        if (sum_nx == '0) st_d  = ST_TGT;
        else              fault = E_BAD_CHK;
      end
      ST_ERR: if (!prog_i) st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
    // Byte-driven outcomes (errors, clean end) beat timeout, which beats abort.
    if (in_session(st) && fault == E_NONE && st_d != ST_IDLE) begin
      if (!rx_dv_i && tcnt == TcLast) fault = E_TIMEOUT;
      else if (!prog_i)               fault = E_ABORT;
    end
    if (fault != E_NONE) st_d = ST_ERR;
  end

  always_comb begin
    we_d    = '0;
    addr_d  = addr_o;
    wdata_d = wdata_o;
    if (st == ST_DATA && word_valid && st_d != ST_ERR) begin
      for (int i = 0; i < NumTgt; i++) we_d[i] = (tgt == TgtW'(i));
      addr_d  = waddr;
      wdata_d = word;
    end
    done_d = (st == ST_TGT) && rx_dv_i && (rx_byte_i == EOS_BYTE);
    busy_d = in_session(st_d);
    prst_d = (st_d == ST_IDLE);
    err_d  = err_o;
    if (st == ST_IDLE && prog_i) err_d = E_NONE;
    else if (fault != E_NONE)    err_d = fault;
  end

  // Frame datapath: target, length, remaining words, address, checksum, idle timer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tgt    <= '0;
      len_lo <= '0;
      sum    <= '0;
      n_rem  <= '0;
      waddr  <= '0;
      tcnt   <= '0;
    end else begin
      tcnt <= (!in_session(st) || rx_dv_i) ? '0 : tcnt + 1'b1;
      if (rx_dv_i) begin
        case (st)
          ST_TGT:  begin tgt <= rx_byte_i[TgtW-1:0]; sum <= rx_byte_i; end
          ST_LEN0: begin len_lo <= rx_byte_i; sum <= sum_nx; end
          ST_LEN1: begin n_rem <= len_nx; waddr <= '0; sum <= sum_nx; end
          ST_DATA: sum <= sum_nx;
          default: ;
        endcase
      end
      if (st == ST_DATA && word_valid) begin
        n_rem <= n_rem - 1'b1;
        waddr <= waddr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of frames, hand-written corner sequences and
// random sessions scored against a frame-level model of expected writes.
module tb_prog_loader;

  localparam int AW = 12;
  localparam int NT = 2;
  localparam int TO = 20;

  logic       clk = 1'b0, rst = 1'b1, prog = 1'b0, rx_dv = 1'b0, sel = 1'b0;
  logic [7:0] rx_byte = '0;

  always #5 clk = ~clk;

  logic [1:0]    we_a, we_b, we_s;
  logic [AW-1:0] addr_a, addr_b, addr_s;
  logic [31:0]   wd_a;
  logic [63:0]   wd_b, wd_s;
  logic          prst_a, prst_b, prst_s, busy_a, busy_b, busy_s, done_a, done_b, done_s;
  logic [2:0]    err_a, err_b, err_s;

  prog_loader #(.DataW(32), .AddrW(AW), .NumTgt(NT), .TimeoutCyc(TO)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .prog_i(prog && !sel), .rx_dv_i(rx_dv && !sel),
    .rx_byte_i(rx_byte), .we_o(we_a), .addr_o(addr_a), .wdata_o(wd_a),
    .prog_rst_no(prst_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a));

  prog_loader #(.DataW(64), .AddrW(AW), .NumTgt(NT), .TimeoutCyc(TO)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .prog_i(prog && sel), .rx_dv_i(rx_dv && sel),
    .rx_byte_i(rx_byte), .we_o(we_b), .addr_o(addr_b), .wdata_o(wd_b),
    .prog_rst_no(prst_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b));

  assign we_s   = sel ? we_b   : we_a;
  assign addr_s = sel ? addr_b : addr_a;
  assign wd_s   = sel ? wd_b   : {32'h0, wd_a};
  assign prst_s = sel ? prst_b : prst_a;
  assign busy_s = sel ? busy_b : busy_a;
  assign done_s = sel ? done_b : done_a;
  assign err_s  = sel ? err_b  : err_a;

  typedef struct { int tgt; int addr; logic [63:0] data; } wr_t;
  typedef struct { logic [7:0] tgt; int n; logic [7:0] dlt; logic [2:0] e_err; int e_wr; } vec_t;

  wr_t         exp_q[$];
  logic [63:0] fixed_w[$];
  int n_vec = 0, n_bad = 0, wr_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Write scoreboard: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (!rst && we_s != '0) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL wr_unexpected: we %0h addr %0h data %0h", we_s, addr_s, wd_s);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_we", 64'(we_s), 64'(1) << e.tgt);
        chk("wr_addr", 64'(addr_s), 64'(e.addr));
        chk("wr_data", wd_s, e.data);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dv = 1'b1; rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
  endtask

  task automatic session_begin();
    prog = 1'b1;
    idle(1);
    chk("ses_busy", 64'(busy_s), 64'd1);
    chk("ses_prst", 64'(prst_s), 64'd0);
    chk("ses_err_clr", 64'(err_s), 64'd0);
  endtask

  task automatic session_end(input logic [2:0] e);
    if (e == 3'd0) begin
      chk("eos_pre_busy", 64'(busy_s), 64'd1);
      chk("eos_pre_prst", 64'(prst_s), 64'd0);
      send_byte(8'hFF);
      prog = 1'b0;
      chk("eos_done", 64'(done_s), 64'd1);
      chk("eos_busy", 64'(busy_s), 64'd0);
      chk("eos_prst", 64'(prst_s), 64'd1);
      chk("eos_err", 64'(err_s), 64'd0);
      idle(1);
      chk("eos_done_end", 64'(done_s), 64'd0);
    end else begin
      chk("err_code", 64'(err_s), 64'(e));
      chk("err_busy", 64'(busy_s), 64'd0);
      chk("err_prst", 64'(prst_s), 64'd0);
      prog = 1'b0;
      idle(1);
      chk("err_idle_prst", 64'(prst_s), 64'd1);
      chk("err_sticky", 64'(err_s), 64'(e));
    end
    chk("wr_missing", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // Frame model: builds the byte stream, queues expected writes, predicts error.
  task automatic run_frame(input logic [7:0] tgt, input int n, input logic [7:0] dlt,
                           input int gapmax, output logic [2:0] merr);
    logic [7:0]  fb[$];
    logic [7:0]  sum, ck;
    logic [63:0] w;
    int bpw;
    bpw  = sel ? 8 : 4;
    merr = 3'd0;
    fb.push_back(tgt);
    if (int'(tgt) >= NT) merr = 3'd1;
    else begin
      fb.push_back(8'(n));
      fb.push_back(8'(n >> 8));
      if (n > (1 << AW)) merr = 3'd2;
      else begin
        for (int i = 0; i < n; i++) begin
          if (fixed_w.size() > 0) w = fixed_w.pop_front();
          else begin
            w = {$urandom, $urandom};
            if (!sel) w[63:32] = '0;
          end
          exp_q.push_back('{int'(tgt), i, w});
          for (int k = 0; k < bpw; k++) fb.push_back(w[8*k +: 8]);
        end
        sum = '0;
        foreach (fb[i]) sum = sum + fb[i];
        ck = 8'h00 - sum + dlt;
        fb.push_back(ck);
        if (dlt != 8'h00) merr = 3'd3;
      end
    end
    foreach (fb[i]) begin
      if (gapmax > 0) idle(int'($urandom_range(gapmax, 0)));
      send_byte(fb[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    logic [2:0] e;
    int w0;

    tbl[0] = '{8'h00, 2,    8'h00, 3'd0, 2};
    tbl[1] = '{8'h01, 1,    8'h01, 3'd3, 1};
    tbl[2] = '{8'h05, 1,    8'h00, 3'd1, 0};
    tbl[3] = '{8'h02, 0,    8'h00, 3'd1, 0};
    tbl[4] = '{8'h00, 4097, 8'h00, 3'd2, 0};
    tbl[5] = '{8'h01, 0,    8'h00, 3'd0, 0};
    tbl[6] = '{8'hFE, 0,    8'h00, 3'd1, 0};
    tbl[7] = '{8'h01, 4096, 8'h00, 3'd0, 4096};
    tbl[8] = '{8'h00, 3,    8'h80, 3'd3, 3};

    repeat (3) @(negedge clk);
    chk("rst_we", 64'(we_s), 64'd0);
    chk("rst_addr", 64'(addr_s), 64'd0);
    chk("rst_wdata", wd_s, 64'd0);
    chk("rst_prst", 64'(prst_s), 64'd1);
    chk("rst_busy", 64'(busy_s), 64'd0);
    chk("rst_err", 64'(err_s), 64'd0);
    rst = 1'b0;
    idle(1);
    chk("rst_done", 64'(done_s), 64'd0);

    // Empty session: start, then end-of-session marker.
    session_begin();
    session_end(3'd0);

    // Table of single-frame sessions.
    for (int i = 0; i < 9; i++) begin
      if (i == 0) begin
        fixed_w.push_back(64'h11223344);
        fixed_w.push_back(64'hAABBCCDD);
      end
      w0 = wr_cnt;
      session_begin();
      run_frame(tbl[i].tgt, tbl[i].n, tbl[i].dlt, 0, e);
      session_end(tbl[i].e_err);
      chk("tbl_wr_cnt", 64'(wr_cnt - w0), 64'(tbl[i].e_wr));
    end

    // Stall exactly TimeoutCyc idle cycles mid-word.
    session_begin();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h44); send_byte(8'h33);
    idle(TO - 1);
    chk("to_pre_busy", 64'(busy_s), 64'd1);
    idle(1);
    session_end(3'd4);

    // Byte arriving on the expiry cycle keeps the session alive.
    session_begin();
    exp_q.push_back('{0, 0, 64'h11223344});
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h44); send_byte(8'h33);
    idle(TO - 1);
    send_byte(8'h22); send_byte(8'h11);
    send_byte(8'h55);
    chk("to_edge_err", 64'(err_s), 64'd0);
    session_end(3'd0);

    // Abort mid-DATA: one word written, then no more.
    w0 = wr_cnt;
    session_begin();
    exp_q.push_back('{0, 0, 64'hCAFEF00D});
    send_byte(8'h00); send_byte(8'h03); send_byte(8'h00);
    send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hFE); send_byte(8'hCA);
    send_byte(8'h01); send_byte(8'h02);
    prog = 1'b0;
    idle(1);
    chk("abort_err", 64'(err_s), 64'd5);
    chk("abort_busy", 64'(busy_s), 64'd0);
    chk("abort_prst", 64'(prst_s), 64'd0);
    send_byte(8'h03); send_byte(8'h04);
    idle(2);
    chk("abort_idle_prst", 64'(prst_s), 64'd1);
    chk("abort_sticky", 64'(err_s), 64'd5);
    chk("abort_wr_cnt", 64'(wr_cnt - w0), 64'd1);
    exp_q.delete();

    // 64-bit words on the wide instance.
    sel = 1'b1;
    idle(1);
    fixed_w.push_back(64'h1122334455667788);
    fixed_w.push_back(64'hAABBCCDDEEFF0011);
    w0 = wr_cnt;
    session_begin();
    run_frame(8'h00, 2, 8'h00, 0, e);
    session_end(e);
    chk("w64_wr_cnt", 64'(wr_cnt - w0), 64'd2);

    // Random multi-frame sessions with random byte gaps.
    for (int s = 0; s < 24; s++) begin
      int nfr, n;
      logic [7:0] tg, dl;
      sel = (s % 4 == 3);
      idle(1);
      session_begin();
      nfr = int'($urandom_range(3, 1));
      e = 3'd0;
      for (int f = 0; f < nfr && e == 3'd0; f++) begin
        tg = ($urandom_range(9, 0) < 8) ? 8'($urandom_range(NT - 1, 0))
                                        : 8'($urandom_range(254, NT));
        n  = ($urandom_range(15, 0) == 0) ? int'($urandom_range(65535, 4097))
                                          : int'($urandom_range(5, 0));
        dl = ($urandom_range(4, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
        run_frame(tg, n, dl, 3, e);
      end
      session_end(e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
